sound_dma: RTL and testbench
============================

SOUND_DMA -- requirements
Module: sound_dma

Interface
REQ-001 SHALL have parameter STATUS_ADDR, default 2'd2, sound-block register address returning {22'd0, wordCount}.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 1024, sound-block sample-buffer capacity in bytes.
REQ-003 SHALL have ports: clk input 1, system clock; reset input 1, asynchronous active-high reset.
REQ-004 SHALL have ports: read, write input 1; address input 2; dataIn input 32, CPU slave request.
REQ-005 SHALL have ports: readValid output 1; dataOut output 32, CPU slave read return.
REQ-006 SHALL have ports: memRead output 1; memAddress output 32; memReadValid input 1; memDataIn input 32, memory read master.
REQ-007 SHALL have ports: sndRead, sndWrite output 1; sndAddress output 2; sndDataOut output 32; sndReadValid input 1; sndDataIn input 32, master to sound block.
REQ-008 SHALL have port dmaIrq output 1, level interrupt.

Function
REQ-009 Slave SHALL register read, write, address, dataIn one cycle, decode on registered copies; readValid two cycles after read; dataOut registered.
REQ-010 Map: 0 srcAddress (RW, bits[1:0] read 0); 1 {16'd0, lengthWords} (RW); 2 control; 3 {16'd0, remaining} (RO).
REQ-011 Control SHALL be: bit0 start (write-1 pulse, reads 0); bit1 ire (RW); bit2 abort (write-1 pulse, reads 0); bit8 busy (RO); bit9 done (write-1 clears); other bits read 0.
REQ-012 Writes to addresses 0/1 while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, FETCH, FWAIT, POLL, PWAIT, PUSH, FINISH.
REQ-014 IDLE+start: curAddr<=srcAddress, remaining<=lengthWords, done<=0, busy<=1; to FINISH if lengthWords==0 else FETCH.
REQ-015 FETCH SHALL assert memRead exactly one cycle with memAddress=curAddr, then go FWAIT.
REQ-016 FWAIT SHALL hold until memReadValid, latch memDataIn, go POLL.
REQ-017 POLL SHALL assert sndRead one cycle with sndAddress=STATUS_ADDR, then go PWAIT.
REQ-018 PWAIT on sndReadValid SHALL go PUSH if BUFFER_DEPTH - sndDataIn[9:0] >= 4, else POLL.
REQ-019 PUSH SHALL assert sndWrite four consecutive cycles, sndAddress=2'd0, sndDataOut={24'd0, byte}, bytes [7:0],[15:8],[23:16],[31:24] in order.
REQ-020 After fourth push: remaining-=1, curAddr+=4 (32-bit wrap); to FINISH if new remaining==0 else FETCH.
REQ-021 FINISH SHALL set done=1, busy=0, go IDLE in one cycle.
REQ-022 dmaIrq SHALL equal done & ire, combinational from registers.
REQ-023 Abort SHALL be sampled into pending flag; honoured at entry to FETCH or POLL, or after current PUSH group completes; FWAIT/PWAIT SHALL still wait for their valid; abort goes IDLE with busy=0, done unchanged.
REQ-024 Abort in IDLE SHALL have no effect; flag cleared on return to IDLE.
REQ-025 memRead, sndRead, sndWrite SHALL never be asserted in the same cycle.
REQ-026 Simultaneous done-clear write and FINISH SHALL leave done=1.

Reset
REQ-027 Reset SHALL force IDLE; srcAddress, lengthWords, remaining, curAddr, latched word 0; ire, busy, done, abort flag 0.
REQ-028 Reset SHALL drive readValid, memRead, sndRead, sndWrite, dmaIrq 0; sndAddress, memAddress 0; dataOut 0.
REQ-029 Reset mid-transfer SHALL abandon all outstanding requests; late memReadValid/sndReadValid in IDLE SHALL be ignored.

Verification
REQ-030 src=0x100, len=2, ire=1, start; memory 0x44332211, 0x88776655; wordCount 0 -> sndDataOut 0x11,0x22,0x33,0x44,0x55..0x88 in order, memAddress 0x100,0x104, dmaIrq=1, remaining=0.
REQ-031 len=1, start; status returns wordCount 1021 three times then 1000 -> three extra POLLs, pushes only after 1000 returned.
REQ-032 len=0, start -> no memRead/sndRead/sndWrite, done=1 within 2 cycles of decoded write.
REQ-033 len=5, abort during second PUSH group -> exactly 8 sndWrite, busy=0, done=0, no dmaIrq.
REQ-034 Write addr0=0x200 while busy -> readback unchanged; write control bit9=1 after done -> done=0, dmaIrq=0.
REQ-035 Reset asserted in FWAIT, then memReadValid -> state IDLE, no sndWrite, all registers at reset values.

Source files
------------

// File: rtl/sound_dma.sv
`default_nettype none
// ============================================================================
// Module   : sound_dma
// Summary  : Word-fetching DMA that streams memory bytes into a sound block,
//            with a four-register CPU slave and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sound_dma #(
  parameter logic [1:0] STATUS_ADDR  = 2'd2,
  parameter int         BUFFER_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // CPU slave
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] dataIn,
  output logic        readValid,
  output logic [31:0] dataOut,
  // memory read master
  output logic        memRead,
  output logic [31:0] memAddress,
  input  logic        memReadValid,
  input  logic [31:0] memDataIn,
  // sound-block master
  output logic        sndRead,
  output logic        sndWrite,
  output logic [1:0]  sndAddress,
  output logic [31:0] sndDataOut,
  input  logic        sndReadValid,
  input  logic [31:0] sndDataIn,
  output logic        dmaIrq
);

  localparam logic [31:0] c_depth = 32'(BUFFER_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    FWAIT  = 3'd2,
    POLL   = 3'd3,
    PWAIT  = 3'd4,
    PUSH   = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_addr;
  logic [31:0] r_din;

  logic [31:0] r_srcAddress;
  logic [15:0] r_lengthWords;
  logic [15:0] r_remaining;
  logic [31:0] r_curAddr;
  logic [31:0] r_word;
  logic [1:0]  r_byteIdx;
  logic        r_ire;
  logic        r_busy;
  logic        r_done;
  logic        r_abortPend;

  logic        w_ctrlWr;
  logic        w_start;
  logic        w_abortWr;
  logic        w_abortNow;
  logic        w_lastByte;
  logic        w_hasRoom;
  logic        w_abortExit;
  logic [7:0]  w_byte;
  logic [31:0] w_rdData;
  logic        w_unusedSnd;

  assign w_ctrlWr    = r_wr && (r_addr == 2'd2);
  assign w_start     = w_ctrlWr && r_din[0];
  assign w_abortWr   = w_ctrlWr && r_din[2];
  assign w_abortNow  = r_abortPend || w_abortWr;
  assign w_lastByte  = (r_byteIdx == 2'd3);
  assign w_byte      = r_word[{r_byteIdx, 3'b000} +: 8];
  // Room check is done as an add so a word count above the depth cannot wrap.
  assign w_hasRoom   = (({22'd0, sndDataIn[9:0]} + 32'd4) <= c_depth);
  assign w_abortExit = (r_state != IDLE) && (r_state != FINISH) && (w_next == IDLE);
  assign w_unusedSnd = ^sndDataIn[31:10];
  assign dmaIrq      = r_done & r_ire;

  // CPU slave: capture the request, decode one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= 2'd0;
      r_din     <= 32'd0;
      readValid <= 1'b0;
      dataOut   <= 32'd0;
    end else begin
      r_rd      <= read;
      r_wr      <= write;
      r_addr    <= address;
      r_din     <= dataIn;
      readValid <= r_rd;
      if (r_rd) begin
        dataOut <= w_rdData;
      end
    end
  end

  always_comb begin
    w_rdData = 32'd0;
    case (r_addr)
      2'd0:    w_rdData = r_srcAddress;
      2'd1:    w_rdData = {16'd0, r_lengthWords};
      2'd2:    w_rdData = {22'd0, r_done, r_busy, 6'd0, r_ire, 1'b0};
      default: w_rdData = {16'd0, r_remaining};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    memRead    = 1'b0;
    memAddress = 32'd0;
    sndRead    = 1'b0;
    sndWrite   = 1'b0;
    sndAddress = 2'd0;
    sndDataOut = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = (r_lengthWords == 16'd0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (w_abortNow) begin
          w_next = IDLE;
        end else begin
          memRead    = 1'b1;
          memAddress = r_curAddr;
          w_next     = FWAIT;
        end
      end
      FWAIT: begin
        if (memReadValid) begin
          w_next = POLL;
        end
      end
      POLL: begin
        if (w_abortNow) begin
          w_next = IDLE;
        end else begin
          sndRead    = 1'b1;
          sndAddress = STATUS_ADDR;
          w_next     = PWAIT;
        end
      end
      PWAIT: begin
        if (sndReadValid) begin
          w_next = w_hasRoom ? PUSH : POLL;
        end
      end
      PUSH: begin
        sndWrite   = 1'b1;
        sndDataOut = {24'd0, w_byte};
        // A whole word always goes out before an abort is taken.
        if (w_lastByte) begin
          if (w_abortNow) begin
            w_next = IDLE;
          end else if (r_remaining == 16'd1) begin
            w_next = FINISH;
          end else begin
            w_next = FETCH;
          end
        end
      end
      FINISH: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_srcAddress  <= 32'd0;
      r_lengthWords <= 16'd0;
      r_remaining   <= 16'd0;
      r_curAddr     <= 32'd0;
      r_word        <= 32'd0;
      r_byteIdx     <= 2'd0;
      r_ire         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_abortPend   <= 1'b0;
    end else begin
      if (r_wr && (r_addr == 2'd0) && !r_busy) begin
        r_srcAddress <= {r_din[31:2], 2'b00};
      end
      if (r_wr && (r_addr == 2'd1) && !r_busy) begin
        r_lengthWords <= r_din[15:0];
      end
      if (w_ctrlWr) begin
        r_ire <= r_din[1];
        if (r_din[9]) begin
          r_done <= 1'b0;
        end
      end

      if ((r_state == IDLE) && w_start) begin
        r_curAddr   <= r_srcAddress;
        r_remaining <= r_lengthWords;
        r_done      <= 1'b0;
        r_busy      <= 1'b1;
      end

      if ((r_state == FWAIT) && memReadValid) begin
        r_word <= memDataIn;
      end

      if (r_state == PUSH) begin
        r_byteIdx <= r_byteIdx + 2'd1;
        if (w_lastByte) begin
          r_remaining <= r_remaining - 16'd1;
          r_curAddr   <= r_curAddr + 32'd4;
        end
      end else begin
        r_byteIdx <= 2'd0;
      end

      // Placed after the clear so completion wins a same-cycle done clear.
      if (r_state == FINISH) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_abortExit) begin
        r_busy <= 1'b0;
      end

      if ((r_state == IDLE) || (w_next == IDLE)) begin
        r_abortPend <= 1'b0;
      end else if (w_abortWr) begin
        r_abortPend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sound_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_dma
// Summary  : Directed register-table and transfer-sequence bench for sound_dma.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] dataIn;
  logic        readValid;
  logic [31:0] dataOut;
  logic        memRead;
  logic [31:0] memAddress;
  logic        memReadValid = 1'b0;
  logic [31:0] memDataIn = 32'd0;
  logic        sndRead;
  logic        sndWrite;
  logic [1:0]  sndAddress;
  logic [31:0] sndDataOut;
  logic        sndReadValid = 1'b0;
  logic [31:0] sndDataIn = 32'd0;
  logic        dmaIrq;

  sound_dma dut (
    .clk(clk), .reset(reset),
    .read(read), .write(write), .address(address), .dataIn(dataIn),
    .readValid(readValid), .dataOut(dataOut),
    .memRead(memRead), .memAddress(memAddress),
    .memReadValid(memReadValid), .memDataIn(memDataIn),
    .sndRead(sndRead), .sndWrite(sndWrite), .sndAddress(sndAddress),
    .sndDataOut(sndDataOut), .sndReadValid(sndReadValid), .sndDataIn(sndDataIn),
    .dmaIrq(dmaIrq)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int lastLat = -1;

  // Responder / monitor state (written only by the monitor process)
  logic [31:0] memAddrLog[$];
  logic [7:0]  sndLog[$];
  int          writeReadsLog[$];
  int          sndReads = 0;
  int          overlap = 0;
  int          badAddr = 0;
  int          statIdx = 0;
  logic        memPend = 1'b0;
  logic [31:0] memPendAddr = 32'd0;
  logic        sndPend = 1'b0;

  // Stimulus controls (written only by the main initial block)
  logic [31:0] statArr[0:127];
  int          statEnd = 0;
  logic        memHold = 1'b0;
  logic        memForce = 1'b0;
  logic        sndForce = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h100: return 32'h44332211;
      32'h104: return 32'h88776655;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    memReadValid = memForce;
    sndReadValid = sndForce;
    if (memPend) begin
      memReadValid = 1'b1;
      memDataIn    = memWord(memPendAddr);
      memPend      = 1'b0;
    end
    if (sndPend) begin
      sndReadValid = 1'b1;
      if (statIdx < statEnd) begin
        sndDataIn = statArr[statIdx];
        statIdx++;
      end else begin
        sndDataIn = 32'd0;
      end
      sndPend = 1'b0;
    end
    if (!reset) begin
      if (memRead) begin
        memAddrLog.push_back(memAddress);
        if (!memHold) begin
          memPend     = 1'b1;
          memPendAddr = memAddress;
        end
      end
      if (sndRead) begin
        sndReads++;
        sndPend = 1'b1;
        if (sndAddress != 2'd2) badAddr++;
      end
      if (sndWrite) begin
        writeReadsLog.push_back(sndReads);
        sndLog.push_back(sndDataOut[7:0]);
        if (sndAddress != 2'd0 || sndDataOut[31:8] != 24'd0) badAddr++;
      end
      if (int'(memRead) + int'(sndRead) + int'(sndWrite) > 1) overlap++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; address = a; dataIn = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic cpuRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
    d = 32'hDEADBEEF;
    lastLat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (readValid) begin
        d = dataOut;
        lastLat = i;
        break;
      end
    end
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cpuRead(a, v);
    check(name, v, exp);
  endtask

  task automatic waitIrq(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dmaIrq) break;
    end
    check(name, {31'd0, dmaIrq}, 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[0:13];

  initial begin
    int memB, sndB, sndRB, wrB;
    logic [31:0] w;
    logic [7:0] expA[0:7];
    bit reached;

    vecs[0]  = '{0, 2'd0, 32'h00000000, "rst_src"};
    vecs[1]  = '{0, 2'd1, 32'h00000000, "rst_len"};
    vecs[2]  = '{0, 2'd2, 32'h00000000, "rst_ctrl"};
    vecs[3]  = '{0, 2'd3, 32'h00000000, "rst_rem"};
    vecs[4]  = '{1, 2'd0, 32'h12345677, "wr_src"};
    vecs[5]  = '{0, 2'd0, 32'h12345674, "src_low_bits"};
    vecs[6]  = '{1, 2'd1, 32'hABCD0007, "wr_len"};
    vecs[7]  = '{0, 2'd1, 32'h00000007, "len_16bit"};
    vecs[8]  = '{1, 2'd2, 32'h00000202, "wr_ctrl_ire"};
    vecs[9]  = '{0, 2'd2, 32'h00000002, "ctrl_ire"};
    vecs[10] = '{1, 2'd3, 32'h0000FFFF, "wr_rem"};
    vecs[11] = '{0, 2'd3, 32'h00000000, "rem_ro"};
    vecs[12] = '{1, 2'd2, 32'h00000104, "wr_abort_idle"};
    vecs[13] = '{0, 2'd2, 32'h00000000, "ctrl_abort_idle"};
    expA = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0; dataIn = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'd0, readValid, memRead, sndRead, sndWrite, dmaIrq}, 32'd0);
    check("rst_dataOut", dataOut, 32'd0);
    check("rst_memAddress", memAddress, 32'd0);
    check("rst_sndAddress", {30'd0, sndAddress}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) cpuWrite(vecs[i].addr, vecs[i].data);
      else begin
        readCheck(vecs[i].name, vecs[i].addr, vecs[i].data);
        if (i == 0) check("read_latency", 32'(lastLat), 32'd0);
      end
    end

    // Two-word transfer with interrupt
    cpuWrite(2'd0, 32'h100);
    cpuWrite(2'd1, 32'd2);
    memB = memAddrLog.size(); sndB = sndLog.size();
    cpuWrite(2'd2, 32'h3);
    waitIrq("xfer2_irq", 200);
    check("xfer2_nwrites", 32'(sndLog.size() - sndB), 32'd8);
    for (int k = 0; k < 8; k++)
      if (sndB + k < sndLog.size()) check($sformatf("xfer2_byte%0d", k), {24'd0, sndLog[sndB + k]}, {24'd0, expA[k]});
    check("xfer2_nfetch", 32'(memAddrLog.size() - memB), 32'd2);
    if (memAddrLog.size() >= memB + 2) begin
      check("xfer2_addr0", memAddrLog[memB], 32'h100);
      check("xfer2_addr1", memAddrLog[memB + 1], 32'h104);
    end
    readCheck("xfer2_remaining", 2'd3, 32'd0);
    readCheck("xfer2_ctrl_done", 2'd2, 32'h202);
    cpuWrite(2'd2, 32'h202);
    readCheck("done_clear_ctrl", 2'd2, 32'h002);
    check("done_clear_irq", {31'd0, dmaIrq}, 32'd0);

    // Back-pressure: three full-buffer polls before space appears
    statArr[statIdx] = 32'd1021; statArr[statIdx + 1] = 32'd1021;
    statArr[statIdx + 2] = 32'd1021; statArr[statIdx + 3] = 32'd1000;
    statEnd = statIdx + 4;
    cpuWrite(2'd0, 32'h300);
    cpuWrite(2'd1, 32'd1);
    sndRB = sndReads; sndB = sndLog.size(); wrB = writeReadsLog.size();
    cpuWrite(2'd2, 32'h3);
    waitIrq("bp_irq", 200);
    check("bp_polls", 32'(sndReads - sndRB), 32'd4);
    check("bp_nwrites", 32'(sndLog.size() - sndB), 32'd4);
    if (writeReadsLog.size() > wrB) check("bp_push_after_poll4", 32'(writeReadsLog[wrB] - sndRB), 32'd4);
    w = memWord(32'h300);
    for (int k = 0; k < 4; k++)
      if (sndB + k < sndLog.size()) check($sformatf("bp_byte%0d", k), {24'd0, sndLog[sndB + k]}, {24'd0, w[8*k +: 8]});
    cpuWrite(2'd2, 32'h202);

    // Zero-length transfer
    memB = memAddrLog.size(); sndB = sndLog.size(); sndRB = sndReads;
    cpuWrite(2'd1, 32'd0);
    cpuWrite(2'd2, 32'h3);
    @(negedge clk);
    @(negedge clk);
    check("zero_len_done", {31'd0, dmaIrq}, 32'd1);
    repeat (5) @(negedge clk);
    check("zero_len_no_traffic", 32'((memAddrLog.size() - memB) + (sndLog.size() - sndB) + (sndReads - sndRB)), 32'd0);
    cpuWrite(2'd2, 32'h202);

    // Register protection while busy (long stall keeps the engine busy)
    for (int k = 0; k < 20; k++) statArr[statIdx + k] = 32'd1021;
    statEnd = statIdx + 20;
    cpuWrite(2'd0, 32'h500);
    cpuWrite(2'd1, 32'd1);
    cpuWrite(2'd2, 32'h3);
    cpuWrite(2'd0, 32'h200);
    cpuWrite(2'd1, 32'd9);
    readCheck("busy_src_kept", 2'd0, 32'h500);
    readCheck("busy_len_kept", 2'd1, 32'd1);
    readCheck("busy_ctrl", 2'd2, 32'h102);
    waitIrq("busy_xfer_irq", 400);
    readCheck("busy_src_after", 2'd0, 32'h500);
    cpuWrite(2'd2, 32'h202);

    // Abort during the second push group
    cpuWrite(2'd0, 32'h400);
    cpuWrite(2'd1, 32'd5);
    memB = memAddrLog.size(); sndB = sndLog.size();
    cpuWrite(2'd2, 32'h3);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sndLog.size() - sndB >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_reach_group2", {31'd0, reached}, 32'd1);
    cpuWrite(2'd2, 32'h6);
    repeat (40) @(negedge clk);
    check("abort_nwrites", 32'(sndLog.size() - sndB), 32'd8);
    check("abort_nfetch", 32'(memAddrLog.size() - memB), 32'd2);
    readCheck("abort_ctrl", 2'd2, 32'h002);
    check("abort_no_irq", {31'd0, dmaIrq}, 32'd0);
    readCheck("abort_remaining", 2'd3, 32'd3);

    // Reset while waiting on memory, then stray responses
    memHold = 1'b1;
    cpuWrite(2'd0, 32'h600);
    cpuWrite(2'd1, 32'd3);
    memB = memAddrLog.size(); sndB = sndLog.size(); sndRB = sndReads;
    cpuWrite(2'd2, 32'h3);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (memAddrLog.size() > memB) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_fwait_reach", {31'd0, reached}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    memForce = 1'b1; sndForce = 1'b1;
    repeat (3) @(negedge clk);
    memForce = 1'b0; sndForce = 1'b0;
    memHold = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_traffic", 32'((memAddrLog.size() - memB) + (sndLog.size() - sndB) + (sndReads - sndRB)), 32'd1);
    check("rst_irq", {31'd0, dmaIrq}, 32'd0);
    readCheck("rst2_src", 2'd0, 32'd0);
    readCheck("rst2_len", 2'd1, 32'd0);
    readCheck("rst2_ctrl", 2'd2, 32'd0);
    readCheck("rst2_rem", 2'd3, 32'd0);

    check("bus_exclusive", 32'(overlap), 32'd0);
    check("snd_addr_data", 32'(badAddr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
